// File: rtl/qmult_pkg.sv
// Shared defaults, FSM encoding and ID-width helper for the arbitrated
// sign-magnitude fixed-point multiplier.
package qmult_pkg;

    localparam int QMULT_Q    = 15;
    localparam int QMULT_N    = 32;
    localparam int QMULT_NREQ = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // A single requester still needs a one-bit ID port.
    function automatic int calc_idw(input int nreq);
        return (nreq > 1) ? $clog2(nreq) : 1;
    endfunction

endpackage

// File: rtl/qmult.sv
// Combinational sign-magnitude fixed-point multiplier: truncates the product
// to Q fractional bits and flags magnitude bits lost above the result.
module qmult
    import qmult_pkg::*;
#(
    parameter int Q = QMULT_Q,
    parameter int N = QMULT_N
) (
    input  logic [N-1:0] i_multiplicand,
    input  logic [N-1:0] i_multiplier,
    output logic [N-1:0] o_result,
    output logic         ovr
);

    logic [2*N-1:0] prod;
    logic           unused_lsb;

    assign prod = {{(N+1){1'b0}}, i_multiplicand[N-2:0]} *
                  {{(N+1){1'b0}}, i_multiplier[N-2:0]};

    assign o_result   = {i_multiplicand[N-1] ^ i_multiplier[N-1], prod[N-2+Q:Q]};
    // The top product bit is always zero; folding it in keeps the slice simple.
    assign ovr        = |prod[2*N-1:N-1+Q];
    assign unused_lsb = ^prod[Q-1:0];

endmodule

// File: rtl/qmult_arbiter.sv
// Round-robin arbiter sharing one qmult among NREQ requesters; each
// operation walks IDLE -> CALC -> RESP with a valid/ready response.
module qmult_arbiter
    import qmult_pkg::*;
#(
    parameter  int Q    = QMULT_Q,
    parameter  int N    = QMULT_N,
    parameter  int NREQ = QMULT_NREQ,
    localparam int IDW  = calc_idw(NREQ)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [NREQ-1:0]   i_req_valid,
    output logic [NREQ-1:0]   o_req_ready,
    input  logic [NREQ*N-1:0] i_req_multiplicand,
    input  logic [NREQ*N-1:0] i_req_multiplier,
    output logic              o_rsp_valid,
    input  logic              i_rsp_ready,
    output logic [N-1:0]      o_rsp_result,
    output logic              o_rsp_ovr,
    output logic [IDW-1:0]    o_rsp_id,
    output logic              o_busy
);

    state_t          state;
    logic [IDW-1:0]  ptr;
    logic [N-1:0]    op_a;
    logic [N-1:0]    op_b;
    logic [IDW-1:0]  op_id;

    logic [NREQ-1:0] grant;
    logic [IDW-1:0]  grant_id;
    logic [IDW-1:0]  cand;
    logic            grant_any;
    logic [N-1:0]    mul_result;
    logic            mul_ovr;

    // NOTE: every always_comb output gets a default before the loop, so no
    // path leaves a variable unassigned and no latch is inferred.
    always_comb begin
        grant     = '0;
        grant_id  = '0;
        grant_any = 1'b0;
        cand      = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand = IDW'((int'(ptr) + 1 + i) % NREQ);
            if (!grant_any && i_req_valid[cand]) begin
                grant_any = 1'b1;
                grant_id  = cand;
            end
        end
        grant[grant_id] = grant_any;
    end

    assign o_req_ready = (state == ST_IDLE && !i_rst) ? grant : '0;

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state        <= ST_IDLE;
            ptr          <= IDW'(NREQ - 1);
            o_rsp_valid  <= 1'b0;
            o_rsp_result <= '0;
            o_rsp_ovr    <= 1'b0;
            o_rsp_id     <= '0;
            o_busy       <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (grant_any) begin
                        ptr    <= grant_id;
                        o_busy <= 1'b1;
                        state  <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    o_rsp_result <= mul_result;
                    o_rsp_ovr    <= mul_ovr;
                    o_rsp_id     <= op_id;
                    o_rsp_valid  <= 1'b1;
                    state        <= ST_RESP;
                end
                ST_RESP: begin
                    if (i_rsp_ready) begin
                        o_rsp_valid <= 1'b0;
                        o_busy      <= 1'b0;
                        state       <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // NOTE: operand registers carry no reset; they are always loaded at
    // acceptance before CALC consumes them.
    always_ff @(posedge i_clk) begin
        if (!i_rst && state == ST_IDLE && grant_any) begin
            op_a  <= i_req_multiplicand[int'(grant_id)*N +: N];
            op_b  <= i_req_multiplier[int'(grant_id)*N +: N];
            op_id <= grant_id;
        end
    end

    qmult #(
        .Q (Q),
        .N (N)
    ) u_qmult (
        .i_multiplicand (op_a),
        .i_multiplier   (op_b),
        .o_result       (mul_result),
        .ovr            (mul_ovr)
    );

endmodule

// File: tb/tb_qmult_arbiter.sv
// Self-checking bench for qmult_arbiter: directed scenarios plus a randomized
// run against a transaction-level arbitration and arithmetic model.
module tb_qmult_arbiter;

    localparam int N    = 32;
    localparam int Q    = 15;
    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic              i_clk = 1'b0;
    logic              i_rst = 1'b1;
    logic [NREQ-1:0]   i_req_valid = '0;
    logic [NREQ-1:0]   o_req_ready;
    logic [NREQ*N-1:0] i_req_multiplicand = '0;
    logic [NREQ*N-1:0] i_req_multiplier = '0;
    logic              o_rsp_valid;
    logic              i_rsp_ready = 1'b0;
    logic [N-1:0]      o_rsp_result;
    logic              o_rsp_ovr;
    logic [IDW-1:0]    o_rsp_id;
    logic              o_busy;

    int n_tests = 0;
    int n_fail  = 0;

    qmult_arbiter #(.Q(Q), .N(N), .NREQ(NREQ)) dut (
        .i_clk              (i_clk),
        .i_rst              (i_rst),
        .i_req_valid        (i_req_valid),
        .o_req_ready        (o_req_ready),
        .i_req_multiplicand (i_req_multiplicand),
        .i_req_multiplier   (i_req_multiplier),
        .o_rsp_valid        (o_rsp_valid),
        .i_rsp_ready        (i_rsp_ready),
        .o_rsp_result       (o_rsp_result),
        .o_rsp_ovr          (o_rsp_ovr),
        .o_rsp_id           (o_rsp_id),
        .o_busy             (o_busy)
    );

    always #5 i_clk = ~i_clk;

    // Reference arithmetic: {ovr, result} from plain 64-bit integer math.
    function automatic logic [N:0] ref_mul(input logic [N-1:0] a, input logic [N-1:0] b);
        longint unsigned ma, mb, p;
        logic [N-1:0]    res;
        logic            ov;
        ma  = longint'(a & 32'h7FFF_FFFF);
        mb  = longint'(b & 32'h7FFF_FFFF);
        p   = ma * mb;
        res = {a[N-1] ^ b[N-1], 31'((p >> Q) & 64'h7FFF_FFFF)};
        ov  = (p >> (N - 1 + Q)) != 0;
        return {ov, res};
    endfunction

    task automatic tick();
        @(posedge i_clk);
        @(negedge i_clk);
    endtask

    task automatic set_ops(input int k, input logic [N-1:0] a, input logic [N-1:0] b);
        i_req_multiplicand[k*N +: N] = a;
        i_req_multiplier[k*N +: N]   = b;
    endtask

    // Runs one isolated operation; lat counts the handshake cycle as 1.
    task automatic run_op(input int k, input logic [N-1:0] a, input logic [N-1:0] b,
                          output logic [N-1:0] res, output logic ov,
                          output logic [IDW-1:0] id, output int lat, output bit ok);
        bit granted;
        granted = 1'b0;
        ok      = 1'b0;
        lat     = 0;
        res     = '0;
        ov      = 1'b0;
        id      = '0;
        set_ops(k, a, b);
        i_req_valid    = '0;
        i_req_valid[k] = 1'b1;
        #1;
        for (int t = 0; t < 8 && !granted; t++) begin
            if (o_req_ready[k]) granted = 1'b1;
            else begin
                tick();
                #1;
            end
        end
        if (granted) begin
            lat = 1;
            tick();
            i_req_valid = '0;
            lat = 2;
            #1;
            while (!o_rsp_valid && lat < 10) begin
                tick();
                #1;
                lat++;
            end
            ok  = o_rsp_valid;
            res = o_rsp_result;
            ov  = o_rsp_ovr;
            id  = o_rsp_id;
            i_rsp_ready = 1'b1;
            tick();
            i_rsp_ready = 1'b0;
        end
        i_req_valid = '0;
    endtask

    task automatic test_reset();
        i_rst       = 1'b1;
        i_req_valid = '1;
        tick();
        tick();
        #1;
        n_tests++;
        if (o_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", o_rsp_valid); end
        n_tests++;
        if (o_rsp_result !== '0) begin n_fail++; $display("FAIL reset_result: got %h expected 0", o_rsp_result); end
        n_tests++;
        if (o_rsp_ovr !== 1'b0 || o_rsp_id !== '0) begin n_fail++; $display("FAIL reset_ovr_id: got %b/%0d expected 0/0", o_rsp_ovr, o_rsp_id); end
        n_tests++;
        if (o_req_ready !== '0 || o_busy !== 1'b0) begin n_fail++; $display("FAIL reset_ready_busy: got %b/%b expected 0000/0", o_req_ready, o_busy); end
        i_rst = 1'b0;
        #1;
        n_tests++;
        if (o_req_ready !== 4'b0001) begin n_fail++; $display("FAIL reset_first_grant: got %b expected 0001", o_req_ready); end
        i_req_valid = '0;
        tick();
    endtask

    task automatic test_single();
        logic [N-1:0] res; logic ov; logic [IDW-1:0] id; int lat; bit ok;
        run_op(0, 32'h0000_C000, 32'h0001_0000, res, ov, id, lat, ok);
        n_tests++;
        if (!ok || lat != 3) begin n_fail++; $display("FAIL single_latency: got ok=%b lat=%0d expected ok=1 lat=3", ok, lat); end
        n_tests++;
        if (res !== 32'h0001_8000 || ov !== 1'b0 || id !== 2'd0) begin
            n_fail++; $display("FAIL single_value: got %h/%b/%0d expected 00018000/0/0", res, ov, id);
        end
    endtask

    task automatic test_sign();
        logic [N-1:0] res; logic ov; logic [IDW-1:0] id; int lat; bit ok;
        run_op(2, 32'h8000_8000, 32'h0000_8000, res, ov, id, lat, ok);
        n_tests++;
        if (!ok || res !== 32'h8000_8000 || ov !== 1'b0 || id !== 2'd2) begin
            n_fail++; $display("FAIL sign_neg: got %h/%b/%0d expected 80008000/0/2", res, ov, id);
        end
        run_op(2, 32'h0000_0000, 32'h8000_8000, res, ov, id, lat, ok);
        n_tests++;
        if (!ok || res !== 32'h8000_0000 || ov !== 1'b0 || id !== 2'd2) begin
            n_fail++; $display("FAIL sign_negzero: got %h/%b/%0d expected 80000000/0/2", res, ov, id);
        end
    endtask

    task automatic test_overflow();
        logic [N-1:0] res; logic ov; logic [IDW-1:0] id; int lat; bit ok;
        logic [N:0] exp;
        exp = ref_mul(32'h7FFF_FFFF, 32'h7FFF_FFFF);
        run_op(1, 32'h7FFF_FFFF, 32'h7FFF_FFFF, res, ov, id, lat, ok);
        n_tests++;
        if (!ok || ov !== 1'b1 || res !== exp[N-1:0] || id !== 2'd1) begin
            n_fail++; $display("FAIL overflow: got %h/%b/%0d expected %h/1/1", res, ov, id, exp[N-1:0]);
        end
    endtask

    task automatic test_fairness();
        logic [N-1:0] fa [NREQ];
        logic [N-1:0] fb [NREQ];
        int exp_ids [6] = '{0, 1, 2, 3, 0, 1};
        int n_rsp, last;
        logic [N:0] exp;
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            fa[k] = $urandom() & 32'h8007_FFFF;
            fb[k] = $urandom() & 32'h8007_FFFF;
            set_ops(k, fa[k], fb[k]);
        end
        i_req_valid = '1;
        i_rsp_ready = 1'b1;
        n_rsp = 0;
        last  = -1;
        for (int c = 0; c < 18; c++) begin
            #1;
            if (o_rsp_valid) begin
                n_tests++;
                if (n_rsp >= 6 || int'(o_rsp_id) != exp_ids[n_rsp % 6]) begin
                    n_fail++; $display("FAIL fair_order: got id %0d at response %0d", o_rsp_id, n_rsp);
                end
                exp = ref_mul(fa[o_rsp_id], fb[o_rsp_id]);
                n_tests++;
                if (o_rsp_result !== exp[N-1:0] || o_rsp_ovr !== exp[N]) begin
                    n_fail++; $display("FAIL fair_value: got %h/%b expected %h/%b", o_rsp_result, o_rsp_ovr, exp[N-1:0], exp[N]);
                end
                n_tests++;
                if (o_req_ready !== '0 || (last >= 0 && c - last != 3)) begin
                    n_fail++; $display("FAIL fair_spacing: got ready %b gap %0d expected 0000 gap 3", o_req_ready, c - last);
                end
                last = c;
                n_rsp++;
            end
            tick();
        end
        i_req_valid = '0;
        i_rsp_ready = 1'b0;
        n_tests++;
        if (n_rsp != 6) begin n_fail++; $display("FAIL fair_count: got %0d expected 6", n_rsp); end
        tick();
    endtask

    task automatic test_backpressure();
        logic [N:0] exp;
        int waited;
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        set_ops(3, 32'h0002_4000, 32'h8001_8000);
        exp = ref_mul(32'h0002_4000, 32'h8001_8000);
        i_req_valid = 4'b1000;
        tick();
        i_req_valid = 4'b0001;
        waited = 0;
        #1;
        while (!o_rsp_valid && waited < 10) begin
            tick();
            #1;
            waited++;
        end
        for (int c = 0; c < 5; c++) begin
            n_tests++;
            if (o_rsp_valid !== 1'b1 || o_req_ready !== '0 || o_rsp_result !== exp[N-1:0] ||
                o_rsp_ovr !== exp[N] || o_rsp_id !== 2'd3) begin
                n_fail++;
                $display("FAIL bp_hold: got v=%b rdy=%b %h/%b/%0d expected v=1 rdy=0000 %h/%b/3",
                         o_rsp_valid, o_req_ready, o_rsp_result, o_rsp_ovr, o_rsp_id, exp[N-1:0], exp[N]);
            end
            tick();
            #1;
        end
        i_rsp_ready = 1'b1;
        #1;
        n_tests++;
        if (o_rsp_valid !== 1'b1 || o_req_ready !== '0) begin
            n_fail++; $display("FAIL bp_release: got v=%b rdy=%b expected v=1 rdy=0000", o_rsp_valid, o_req_ready);
        end
        tick();
        i_rsp_ready = 1'b0;
        #1;
        n_tests++;
        if (o_rsp_valid !== 1'b0 || o_busy !== 1'b0 || o_req_ready !== 4'b0001) begin
            n_fail++; $display("FAIL bp_idle: got v=%b busy=%b rdy=%b expected 0/0/0001", o_rsp_valid, o_busy, o_req_ready);
        end
        i_req_valid = '0;
        tick();
    endtask

    task automatic test_reset_in_calc();
        set_ops(2, 32'h0001_0000, 32'h0001_0000);
        i_req_valid = 4'b0100;
        #1;
        n_tests++;
        if (o_req_ready !== 4'b0100) begin n_fail++; $display("FAIL rcalc_grant: got %b expected 0100", o_req_ready); end
        tick();
        i_req_valid = '0;
        i_rst = 1'b1;
        tick();
        #1;
        n_tests++;
        if (o_rsp_valid !== 1'b0 || o_busy !== 1'b0 || o_rsp_result !== '0 || o_rsp_ovr !== 1'b0 || o_rsp_id !== '0) begin
            n_fail++; $display("FAIL rcalc_values: got v=%b busy=%b %h/%b/%0d expected all zero",
                               o_rsp_valid, o_busy, o_rsp_result, o_rsp_ovr, o_rsp_id);
        end
        i_rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            #1;
            n_tests++;
            if (o_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rcalc_no_rsp: got %b expected 0", o_rsp_valid); end
        end
        i_req_valid = '1;
        #1;
        n_tests++;
        if (o_req_ready !== 4'b0001) begin n_fail++; $display("FAIL rcalc_next_grant: got %b expected 0001", o_req_ready); end
        i_req_valid = '0;
        tick();
    endtask

    task automatic test_random();
        int           m_ptr, m_age, win;
        bit           m_out;
        logic [N:0]   m_exp;
        int           m_id;
        logic [NREQ-1:0] exp_ready;
        logic [N-1:0] ra [NREQ];
        logic [N-1:0] rb [NREQ];
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        m_ptr = NREQ - 1;
        m_out = 1'b0;
        m_age = 0;
        m_id  = 0;
        m_exp = '0;
        for (int c = 0; c < 400; c++) begin
            i_req_valid = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom_range(0, 15));
            i_rsp_ready = 1'($urandom_range(0, 1));
            for (int k = 0; k < NREQ; k++) begin
                ra[k] = {1'($urandom_range(0, 1)), 31'($urandom() >> $urandom_range(1, 24))};
                rb[k] = {1'($urandom_range(0, 1)), 31'($urandom() >> $urandom_range(1, 24))};
                set_ops(k, ra[k], rb[k]);
            end
            #1;
            win = -1;
            exp_ready = '0;
            if (!m_out) begin
                for (int i = 0; i < NREQ; i++) begin
                    if (win < 0 && i_req_valid[(m_ptr + 1 + i) % NREQ]) win = (m_ptr + 1 + i) % NREQ;
                end
                if (win >= 0) exp_ready[win] = 1'b1;
            end
            n_tests++;
            if (o_req_ready !== exp_ready) begin n_fail++; $display("FAIL rnd_ready c%0d: got %b expected %b", c, o_req_ready, exp_ready); end
            n_tests++;
            if (o_busy !== m_out) begin n_fail++; $display("FAIL rnd_busy c%0d: got %b expected %b", c, o_busy, m_out); end
            n_tests++;
            if (o_rsp_valid !== (m_out && m_age == 2)) begin
                n_fail++; $display("FAIL rnd_valid c%0d: got %b expected %b", c, o_rsp_valid, m_out && m_age == 2);
            end
            if (m_out && m_age == 2 && o_rsp_valid) begin
                n_tests++;
                if (o_rsp_result !== m_exp[N-1:0] || o_rsp_ovr !== m_exp[N] || int'(o_rsp_id) != m_id) begin
                    n_fail++; $display("FAIL rnd_value c%0d: got %h/%b/%0d expected %h/%b/%0d",
                                       c, o_rsp_result, o_rsp_ovr, o_rsp_id, m_exp[N-1:0], m_exp[N], m_id);
                end
            end
            if (win >= 0) begin
                m_out = 1'b1;
                m_age = 1;
                m_ptr = win;
                m_id  = win;
                m_exp = ref_mul(ra[win], rb[win]);
            end else if (m_out) begin
                if (m_age == 2) begin
                    if (i_rsp_ready) m_out = 1'b0;
                end else begin
                    m_age++;
                end
            end
            tick();
        end
        i_req_valid = '0;
        i_rsp_ready = 1'b1;
        tick();
        tick();
        tick();
        i_rsp_ready = 1'b0;
    endtask

    initial begin
        @(negedge i_clk);
        test_reset();
        test_single();
        test_sign();
        test_overflow();
        test_fairness();
        test_backpressure();
        test_reset_in_calc();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
